// File: rtl/dpe_ingress_fifo.sv
// Store-and-forward ingress FIFO: packets become visible downstream only once
// their last beat is committed; overflowing packets are dropped whole.
// Optional: define DPE_INGRESS_DROP_CNT_EN to add a saturating drop_count output.
module dpe_ingress_fifo #(
  parameter int DATA_W = 128,
  parameter int KEEP_W = DATA_W/8,
  parameter int DEPTH  = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     s_tvalid,
  output logic                     s_tready,
  input  logic [DATA_W-1:0]        s_tdata,
  input  logic [KEEP_W-1:0]        s_tkeep,
  input  logic                     s_tlast,
  output logic                     m_tvalid,
  input  logic                     m_tready,
  output logic [DATA_W-1:0]        m_tdata,
  output logic [KEEP_W-1:0]        m_tkeep,
  output logic                     m_tlast,
  output logic [$clog2(DEPTH):0]   pkt_count,
`ifdef DPE_INGRESS_DROP_CNT_EN
  output logic                     drop_pulse,
  output logic [15:0]              drop_count
`else
  output logic                     drop_pulse
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  typedef struct packed {
    logic              last;
    logic [KEEP_W-1:0] keep;
    logic [DATA_W-1:0] data;
  } beat_t;

  typedef enum logic [1:0] {IDLE, WRITE, DROP} wr_state_e;

  wr_state_e state, state_nxt;

  beat_t mem [DEPTH];

  logic [PW-1:0] wr_ptr, wr_commit, commit_q, rd_ptr, used;
  logic          full, accept, wr_en, commit, drop_hit;
  logic          rd_avail, rd_load, xfer_last;

  assign used     = wr_ptr - rd_ptr;
  assign full     = (used == PW'(DEPTH));
  assign accept   = s_tvalid & s_tready;

  // ---------------- write FSM ----------------
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, WRITE:
        if (accept) begin
          if (full)         state_nxt = s_tlast ? IDLE : DROP;
          else if (s_tlast) state_nxt = IDLE;
          else              state_nxt = WRITE;
        end
      DROP:
        if (accept && s_tlast) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    wr_en    = 1'b0;
    commit   = 1'b0;
    drop_hit = 1'b0;
    case (state)
      IDLE, WRITE:
        if (accept) begin
          if (full) drop_hit = 1'b1;
          else begin
            wr_en  = 1'b1;
            commit = s_tlast;
          end
        end
      default: ;
    endcase
  end

  // ---------------- write side ----------------
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s_tready   <= 1'b0;
      wr_ptr     <= '0;
      wr_commit  <= '0;
      drop_pulse <= 1'b0;
    end else begin
      s_tready   <= 1'b1;
      drop_pulse <= drop_hit;
      if (drop_hit)   wr_ptr <= wr_commit;
      else if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      if (commit)     wr_commit <= wr_ptr + PW'(1);
    end

  always_ff @(posedge clk)
    if (wr_en) mem[wr_ptr[AW-1:0]] <= '{last: s_tlast, keep: s_tkeep, data: s_tdata};

  // ---------------- read side ----------------
  // The read side sees the commit pointer one cycle late, so a freshly
  // committed word is never read in the same cycle its commit is registered.
  assign rd_avail  = (rd_ptr != commit_q);
  assign rd_load   = rd_avail & (~m_tvalid | m_tready);
  assign xfer_last = m_tvalid & m_tready & m_tlast;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      commit_q <= '0;
      rd_ptr   <= '0;
      m_tvalid <= 1'b0;
      m_tdata  <= '0;
      m_tkeep  <= '0;
      m_tlast  <= 1'b0;
    end else begin
      commit_q <= wr_commit;
      if (rd_load) begin
        rd_ptr   <= rd_ptr + PW'(1);
        m_tvalid <= 1'b1;
        {m_tlast, m_tkeep, m_tdata} <= mem[rd_ptr[AW-1:0]];
      end else if (m_tready) begin
        m_tvalid <= 1'b0;
      end
    end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) pkt_count <= '0;
    else case ({commit, xfer_last})
      2'b10:   pkt_count <= pkt_count + PW'(1);
      2'b01:   pkt_count <= pkt_count - PW'(1);
      default: pkt_count <= pkt_count;
    endcase

`ifdef DPE_INGRESS_DROP_CNT_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)                              drop_count <= '0;
    else if (drop_pulse && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
`endif

endmodule

// File: tb/tb_dpe_ingress_fifo.sv
// Randomized + directed bench for dpe_ingress_fifo (DEPTH=16) against a
// packet-level scoreboard: beats become expected only once their packet ends.
module tb_dpe_ingress_fifo;
  localparam int DATA_W = 32;
  localparam int KEEP_W = 4;
  localparam int DEPTH  = 16;
  localparam int PW     = $clog2(DEPTH) + 1;

  logic              clk, rst_n;
  logic              s_tvalid, s_tready, s_tlast;
  logic [DATA_W-1:0] s_tdata;
  logic [KEEP_W-1:0] s_tkeep;
  logic              m_tvalid, m_tready, m_tlast;
  logic [DATA_W-1:0] m_tdata;
  logic [KEEP_W-1:0] m_tkeep;
  logic [PW-1:0]     pkt_count;
  logic              drop_pulse;
`ifdef DPE_INGRESS_DROP_CNT_EN
  logic [15:0]       drop_count;
`endif

  dpe_ingress_fifo #(.DATA_W(DATA_W), .KEEP_W(KEEP_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
    .s_tkeep(s_tkeep), .s_tlast(s_tlast),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata),
    .m_tkeep(m_tkeep), .m_tlast(m_tlast),
    .pkt_count(pkt_count),
`ifdef DPE_INGRESS_DROP_CNT_EN
    .drop_pulse(drop_pulse), .drop_count(drop_count)
`else
    .drop_pulse(drop_pulse)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [DATA_W-1:0] d;
    logic [KEEP_W-1:0] k;
    logic              l;
  } beat_t;

  beat_t pend[$], expq[$];
  int    n_vec, n_err;
  int    model_cnt, peak_cnt, drops_seen, drops_exp, beats_out, words_in, words_out;
  bit    cur_drop, stall_prev;
  logic [DATA_W+KEEP_W:0] prev_out;
  int    ready_mode;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Downstream ready pattern
  initial begin
    m_tready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       m_tready = 1'b1;
        1:       m_tready = ~m_tready;
        2:       m_tready = 1'b0;
        default: m_tready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor / scoreboard: events seen here take effect at the next posedge
  always @(negedge clk) begin
    if (!rst_n) begin
      pend.delete(); expq.delete();
      model_cnt = 0; words_in = 0; words_out = 0; stall_prev = 0;
    end else begin
      chk("pkt_count", 64'(pkt_count), 64'(model_cnt));
      if (int'(pkt_count) > peak_cnt) peak_cnt = int'(pkt_count);
      if (drop_pulse) drops_seen++;
      if (stall_prev) begin
        chk("stall_vld", 64'(m_tvalid), 64'(1));
        chk("stall_dat", 64'({m_tlast, m_tkeep, m_tdata}), 64'(prev_out));
      end
      stall_prev = m_tvalid && !m_tready;
      prev_out   = {m_tlast, m_tkeep, m_tdata};
      if (m_tvalid && m_tready) begin
        chk("out_avail", 64'(expq.size() > 0), 64'(1));
        if (expq.size() > 0) begin
          beat_t e;
          e = expq.pop_front();
          chk("out_beat", 64'({m_tlast, m_tkeep, m_tdata}), 64'({e.l, e.k, e.d}));
          if (e.l) model_cnt--;
        end
        beats_out++; words_out++;
      end
      if (s_tvalid && s_tready && !cur_drop) begin
        beat_t b;
        b.d = s_tdata; b.k = s_tkeep; b.l = s_tlast;
        pend.push_back(b);
        words_in++;
        if (s_tlast) begin
          foreach (pend[i]) expq.push_back(pend[i]);
          pend.delete();
          model_cnt++;
        end
      end
    end
  end

  task automatic send_pkt(input int len, input int base, input bit drop, input bit gaps);
    cur_drop = drop;
    if (drop) drops_exp++;
    for (int i = 0; i < len; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        s_tvalid = 1'b0; @(posedge clk); #1;
      end
      s_tvalid = 1'b1;
      s_tdata  = DATA_W'(base + i);
      s_tkeep  = KEEP_W'($urandom);
      s_tlast  = (i == len - 1);
      @(posedge clk); #1;
    end
    s_tvalid = 1'b0; s_tlast = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
  endtask

  task automatic drain();
    int c;
    c = 0;
    ready_mode = 0;
    while ((expq.size() != 0 || m_tvalid) && c < 300) begin
      @(posedge clk); #1; c++;
    end
    chk("drain_timeout", 64'(c < 300), 64'(1));
    idle(2);
  endtask

  task automatic new_test();
    peak_cnt = 0; beats_out = 0; drops_seen = 0; drops_exp = 0;
  endtask

  initial begin
    int total;
    rst_n = 1'b1; s_tvalid = 0; s_tdata = '0; s_tkeep = '0; s_tlast = 0;
    ready_mode = 2; cur_drop = 0;
    n_vec = 0; n_err = 0;
    new_test();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_s_tready", 64'(s_tready), 64'(0));
    chk("rst_m_tvalid", 64'(m_tvalid), 64'(0));
    chk("rst_m_tdata",  64'(m_tdata),  64'(0));
    chk("rst_pkt_cnt",  64'(pkt_count), 64'(0));
    chk("rst_drop",     64'(drop_pulse), 64'(0));
    idle(3);
    rst_n = 1'b1;
    idle(1);
    chk("s_tready_hi", 64'(s_tready), 64'(1));

    // Single packet latency and ordering
    new_test(); ready_mode = 0; idle(1);
    send_pkt(4, 'h29, 0, 0);
    chk("lat_k",  64'(m_tvalid), 64'(0));
    idle(1);
    chk("lat_k1", 64'(m_tvalid), 64'(0));
    idle(1);
    chk("lat_k2", 64'(m_tvalid), 64'(1));
    chk("first_data", 64'(m_tdata), 64'('h29));
    drain();
    chk("a_beats", 64'(beats_out), 64'(4));
    chk("a_peak",  64'(peak_cnt), 64'(1));

    // Two packets under toggling ready
    new_test(); ready_mode = 1;
    send_pkt(6, 'h01, 0, 0);
    send_pkt(4, 'h0B, 0, 0);
    drain();
    chk("b_peak",  64'(peak_cnt), 64'(2));
    chk("b_beats", 64'(beats_out), 64'(10));

    // Oversize packet dropped, next one intact
    new_test(); ready_mode = 0;
    send_pkt(20, 'h40, 1, 0);
    idle(4);
    chk("c_drops", 64'(drops_seen), 64'(drops_exp));
    chk("c_none",  64'(beats_out), 64'(0));
    send_pkt(4, 'h60, 0, 0);
    drain();
    chk("c_beats", 64'(beats_out), 64'(4));

    // Fill with ready low, fourth packet overflows
    new_test(); ready_mode = 2; idle(2);
    send_pkt(5, 'h70, 0, 0);
    send_pkt(5, 'h80, 0, 0);
    send_pkt(5, 'h90, 0, 0);
    send_pkt(5, 'hA0, 1, 0);
    idle(4);
    chk("d_drops", 64'(drops_seen), 64'(drops_exp));
    chk("d_cnt",   64'(pkt_count), 64'(3));
    drain();
    chk("d_beats", 64'(beats_out), 64'(15));

    // Reset mid-packet
    new_test(); ready_mode = 0;
    for (int i = 0; i < 2; i++) begin
      s_tvalid = 1; s_tdata = DATA_W'('hC0 + i); s_tkeep = 4'hF; s_tlast = 0;
      @(posedge clk); #1;
    end
    s_tdata = DATA_W'('hC2);
    #2 rst_n = 1'b0;
    #1;
    chk("e_s_tready", 64'(s_tready), 64'(0));
    chk("e_m_tvalid", 64'(m_tvalid), 64'(0));
    chk("e_m_tdata",  64'(m_tdata),  64'(0));
    chk("e_m_tkeep",  64'(m_tkeep),  64'(0));
    chk("e_m_tlast",  64'(m_tlast),  64'(0));
    chk("e_pkt_cnt",  64'(pkt_count), 64'(0));
    s_tvalid = 0;
    idle(2);
    rst_n = 1'b1;
    idle(1);
    beats_out = 0;
    send_pkt(4, 'h15, 0, 0);
    drain();
    chk("e_beats", 64'(beats_out), 64'(4));

    // Randomized packets with random ready, kept clear of overflow
    new_test(); ready_mode = 3; total = 0;
    for (int p = 0; p < 40; p++) begin
      int len, c;
      len = $urandom_range(1, 6);
      c = 0;
      while ((words_in - words_out) + len > DEPTH && c < 200) begin
        @(posedge clk); #1; c++;
      end
      chk("f_space_to", 64'(c < 200), 64'(1));
      send_pkt(len, int'($urandom_range(0, 'hFFFF)) << 8, 0, 1);
      total += len;
    end
    drain();
    chk("f_beats", 64'(beats_out), 64'(total));
    chk("f_drops", 64'(drops_seen), 64'(0));

`ifdef DPE_INGRESS_DROP_CNT_EN
    rst_n = 1'b0; idle(1); rst_n = 1'b1; idle(1);
    chk("g_cnt0", 64'(drop_count), 64'(0));
    new_test(); ready_mode = 0;
    send_pkt(18, 'h100, 1, 0);
    send_pkt(25, 'h200, 1, 0);
    idle(3);
    chk("g_drop_count", 64'(drop_count), 64'(2));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
